// File: rtl/buscar_pkg.sv
// Shared types and defaults for the sequential search/assign matrix.
// State encoding, default geometry, and the linear-index to {row, col} helper.
package buscar_pkg;

  localparam int unsigned DEF_ROWS   = 8;
  localparam int unsigned DEF_COLS   = 8;
  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_KEY_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-major linear index -> {row[63:32], col[31:0]}.
  // The caller passes a constant column count, so the divide folds to wiring.
  function automatic logic [63:0] idx_to_rc(input logic [31:0] idx,
                                            input logic [31:0] cols);
    logic [31:0] row;
    logic [31:0] col;
    row = idx / cols;
    col = idx % cols;
    return {row, col};
  endfunction

endpackage

// File: rtl/buscar_cell_cmp.sv
// Per-cell match decision and replacement data for the scan engine.
// A cell matches when its value field equals the key and its tag field is
// still zero. With BUSCAR_KEY_MASK_EN defined, only the bits selected by the
// latched mask take part in the value comparison.
module buscar_cell_cmp
  import buscar_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned KEY_W  = DEF_KEY_W
) (
  input  logic [DATA_W-1:0]       i_cell,
  input  logic [KEY_W-1:0]        i_key,
  input  logic [DATA_W-KEY_W-1:0] i_tag,
`ifdef BUSCAR_KEY_MASK_EN
  input  logic [KEY_W-1:0]        i_mask,
`endif
  output logic                    o_match,
  output logic [DATA_W-1:0]       o_next_cell
);

  localparam int unsigned TAG_W = DATA_W - KEY_W;

  logic [KEY_W-1:0] w_value;
  logic [TAG_W-1:0] w_cur_tag;
  logic             w_value_eq;

  assign w_value   = i_cell[KEY_W-1:0];
  assign w_cur_tag = i_cell[DATA_W-1:KEY_W];

`ifdef BUSCAR_KEY_MASK_EN
  assign w_value_eq = (((w_value ^ i_key) & i_mask) == {KEY_W{1'b0}});
`else
  assign w_value_eq = (w_value == i_key);
`endif

  assign o_match     = w_value_eq && (w_cur_tag == {TAG_W{1'b0}});
  // Value field is preserved; only the tag field is replaced.
  assign o_next_cell = {i_tag, w_value};

endmodule

// File: rtl/buscar_asignar_seq.sv
// Sequential search/assign matrix. Scans ROWS x COLS cells one per clock in
// row-major order, tags unassigned cells whose value equals the key, and
// reports the match count and first match position.
// Optional build macro: BUSCAR_KEY_MASK_EN (adds key_mask input).
module buscar_asignar_seq
  import buscar_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned KEY_W  = DEF_KEY_W,
  localparam int unsigned TAG_W = DATA_W - KEY_W,
  localparam int unsigned RW    = $clog2(ROWS),
  localparam int unsigned CW    = $clog2(COLS),
  localparam int unsigned NW    = $clog2(ROWS*COLS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  input  logic [TAG_W-1:0]  tag,
  input  logic              first_only,
`ifdef BUSCAR_KEY_MASK_EN
  input  logic [KEY_W-1:0]  key_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [NW-1:0]     match_count,
  output logic [RW-1:0]     first_row,
  output logic [CW-1:0]     first_col
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [N-1:0][DATA_W-1:0] r_mem;
  logic [DATA_W-1:0]        r_rd_data;

  logic [KEY_W-1:0] r_key;
  logic [TAG_W-1:0] r_tag;
  logic             r_first_only;
`ifdef BUSCAR_KEY_MASK_EN
  logic [KEY_W-1:0] r_mask;
`endif
  logic [IW-1:0]    r_idx;
  logic [NW-1:0]    r_count;
  logic             r_found;
  logic [RW-1:0]    r_first_row;
  logic [CW-1:0]    r_first_col;
  logic             r_busy;
  logic             r_done;

  logic              w_accept;
  logic              w_hit;
  logic              w_cmp_match;
  logic [DATA_W-1:0] w_cur_cell;
  logic [DATA_W-1:0] w_next_cell;
  logic [RW-1:0]     w_scan_row;
  logic [CW-1:0]     w_scan_col;
  logic              w_wr_ok;
  logic [IW-1:0]     w_wr_lin;
  logic              w_rd_ok;
  logic [IW-1:0]     w_rd_lin;

  // Port addresses outside the configured geometry are rejected here;
  // comparisons are widened to 32 bits so non-power-of-2 sizes work.
  assign w_wr_ok  = wr_en && (r_state == IDLE) &&
                    (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign w_wr_lin = IW'(32'(wr_row) * COLS + 32'(wr_col));
  assign w_rd_ok  = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign w_rd_lin = IW'(32'(rd_row) * COLS + 32'(rd_col));

  assign w_cur_cell = r_mem[r_idx];
  assign w_hit      = (r_state == SCAN) && w_cmp_match;

  assign w_scan_row = RW'(idx_to_rc(32'(r_idx), 32'(COLS)) >> 32);
  assign w_scan_col = CW'(idx_to_rc(32'(r_idx), 32'(COLS)));

  buscar_cell_cmp #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W)
  ) u_cmp (
    .i_cell      (w_cur_cell),
    .i_key       (r_key),
    .i_tag       (r_tag),
`ifdef BUSCAR_KEY_MASK_EN
    .i_mask      (r_mask),
`endif
    .o_match     (w_cmp_match),
    .o_next_cell (w_next_cell)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start accepted only in IDLE, scan ends on the last cell
  // or on the first hit in first-only mode, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if ((r_idx == LAST_IDX) || (w_hit && r_first_only)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SCAN;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Search parameters latched at start, plus the scan index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key        <= {KEY_W{1'b0}};
      r_tag        <= {TAG_W{1'b0}};
      r_first_only <= 1'b0;
`ifdef BUSCAR_KEY_MASK_EN
      r_mask       <= {KEY_W{1'b0}};
`endif
      r_idx        <= {IW{1'b0}};
    end else if (w_accept) begin
      r_key        <= key;
      r_tag        <= tag;
      r_first_only <= first_only;
`ifdef BUSCAR_KEY_MASK_EN
      r_mask       <= key_mask;
`endif
      r_idx        <= {IW{1'b0}};
    end else if ((r_state == SCAN) && (w_state_nxt == SCAN)) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  // Result registers: cleared at start, updated on each hit, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= {NW{1'b0}};
      r_found     <= 1'b0;
      r_first_row <= {RW{1'b0}};
      r_first_col <= {CW{1'b0}};
    end else if (w_accept) begin
      r_count     <= {NW{1'b0}};
      r_found     <= 1'b0;
      r_first_row <= {RW{1'b0}};
      r_first_col <= {CW{1'b0}};
    end else if (w_hit) begin
      r_count <= r_count + NW'(1);
      r_found <= 1'b1;
      if (!r_found) begin
        r_first_row <= w_scan_row;
        r_first_col <= w_scan_col;
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // Cell storage: load port writes in IDLE, tag assignment during SCAN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= {(N*DATA_W){1'b0}};
    end else if (w_wr_ok) begin
      r_mem[w_wr_lin] <= wr_data;
    end else if (w_hit) begin
      r_mem[r_idx] <= w_next_cell;
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= {DATA_W{1'b0}};
    end else if (w_rd_ok) begin
      r_rd_data <= r_mem[w_rd_lin];
    end else begin
      r_rd_data <= {DATA_W{1'b0}};
    end
  end

  assign rd_data     = r_rd_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign match_count = r_count;
  assign first_row   = r_first_row;
  assign first_col   = r_first_col;

endmodule

// File: tb/tb_buscar_asignar_seq.sv
// Directed bench for buscar_asignar_seq (8x8, 10-bit cells, 6-bit value).
// Expected search results come from a reference matrix model and are queued
// when a search is launched, then popped and compared when done fires.
// Build with BUSCAR_KEY_MASK_EN to include the masked-key step.
module tb_buscar_asignar_seq;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [9:0] wr_data;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [9:0] rd_data;
  logic       start;
  logic [5:0] key;
  logic [3:0] tag;
  logic       first_only;
  logic [5:0] key_mask;
  logic       busy;
  logic       done;
  logic       found;
  logic [6:0] match_count;
  logic [2:0] first_row;
  logic [2:0] first_col;

  typedef struct {
    int cnt;
    int fnd;
    int row;
    int col;
    int lat;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] mdl [64];
  int         errors = 0;
  int         checks = 0;

  buscar_asignar_seq dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .start       (start),
    .key         (key),
    .tag         (tag),
    .first_only  (first_only),
`ifdef BUSCAR_KEY_MASK_EN
    .key_mask    (key_mask),
`endif
    .busy        (busy),
    .done        (done),
    .found       (found),
    .match_count (match_count),
    .first_row   (first_row),
    .first_col   (first_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic wr(input int r, input int c, input logic [9:0] d);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_col  = 3'(c);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mdl[r*8+c] = d;
  endtask

  task automatic rd_chk(input string name, input int r, input int c);
    rd_row = 3'(r);
    rd_col = 3'(c);
    tick();
    chk(name, rd_data, mdl[r*8+c]);
  endtask

  // Reference search over the model matrix; queues the expected outcome.
  task automatic model_search(input logic [5:0] k, input logic [3:0] t,
                              input logic fo, input logic [5:0] m);
    exp_t e;
    e.cnt = 0; e.fnd = 0; e.row = 0; e.col = 0; e.lat = 64;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      logic [3:0] ct;
      v  = mdl[i][5:0];
      ct = mdl[i][9:6];
      if (((v & m) == (k & m)) && (ct == 4'd0)) begin
        mdl[i] = {t, v};
        e.cnt++;
        if (e.fnd == 0) begin
          e.fnd = 1;
          e.row = i / 8;
          e.col = i % 8;
        end
        if (fo) begin
          e.lat = i + 1;
          break;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_search(input string name, input logic [5:0] k, input logic [3:0] t,
                            input logic fo, input logic [5:0] m, input bit disturb);
    exp_t e;
    int   cyc;
    bit   seen;
    model_search(k, t, fo, m);
    key = k; tag = t; first_only = fo; key_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    cyc  = 0;
    seen = 0;
    while (cyc < 200 && !seen) begin
      if (disturb && cyc == 10) begin
        start = 1'b1; key = 6'd7; tag = 4'd9; first_only = 1'b1;
        wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd3; wr_data = 10'h03F;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      tick();
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    chk({name, "_done_seen"}, 32'(seen), 1);
    e = sb.pop_front();
    chk({name, "_latency"}, cyc, e.lat);
    chk({name, "_count"}, match_count, e.cnt);
    chk({name, "_found"}, found, e.fnd);
    chk({name, "_first_row"}, first_row, e.row);
    chk({name, "_first_col"}, first_col, e.col);
    tick();
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_idle"}, busy, 0);
    tick();
    chk({name, "_count_hold"}, match_count, e.cnt);
  endtask

  task automatic load_linear();
    for (int i = 0; i < 64; i++) wr(i / 8, i % 8, 10'(i));
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_data = 10'd0;
    rd_row = 3'd0; rd_col = 3'd0; start = 1'b0; key = 6'd0; tag = 4'd0;
    first_only = 1'b0; key_mask = 6'h3F;
    for (int i = 0; i < 64; i++) mdl[i] = 10'd0;
    repeat (3) tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_count", match_count, 0);
    chk("rst_first_row", first_row, 0);
    chk("rst_first_col", first_col, 0);
    rst = 1'b1;
    tick();

    // Linear board, single match of key 5.
    load_linear();
    rd_chk("rd_lin_23", 2, 3);
    run_search("s_k5", 6'd5, 4'd3, 1'b0, 6'h3F, 1'b0);
    rd_chk("rd_05_tagged", 0, 5);
    chk("rd_05_const", rd_data, 10'h0C5);

    // Search-only pass: tag 0 counts but leaves the cell unassigned.
    run_search("s_tag0", 6'd9, 4'd0, 1'b0, 6'h3F, 1'b0);
    rd_chk("rd_11_untagged", 1, 1);

    // Uniform board, first-only then assign-all.
    for (int i = 0; i < 64; i++) wr(i / 8, i % 8, 10'd7);
    run_search("s_first", 6'd7, 4'd1, 1'b1, 6'h3F, 1'b0);
    rd_chk("rd_00_tag1", 0, 0);
    chk("rd_00_const", rd_data, 10'h047);
    rd_chk("rd_01_untagged", 0, 1);
    run_search("s_all", 6'd7, 4'd2, 1'b0, 6'h3F, 1'b0);
    rd_chk("rd_00_keeps", 0, 0);
    rd_chk("rd_77_tag2", 7, 7);

    // No match; start pulse and write issued mid-scan must be ignored.
    run_search("s_none", 6'd63, 4'd5, 1'b0, 6'h3F, 1'b1);
    rd_chk("rd_33_no_write", 3, 3);

    // Reset mid-scan at index 30.
    load_linear();
    key = 6'd5; tag = 4'd3; first_only = 1'b0; key_mask = 6'h3F;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst = 1'b0;
    #1;
    chk("abort_count", match_count, 0);
    chk("abort_found", found, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_first_col", first_col, 0);
    chk("abort_rd_data", rd_data, 0);
    for (int i = 0; i < 64; i++) mdl[i] = 10'd0;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rd_chk("abort_mem_cleared", 0, 5);
    load_linear();
    run_search("s_after", 6'd5, 4'd3, 1'b0, 6'h3F, 1'b0);
    rd_chk("rd_05_after", 0, 5);

`ifdef BUSCAR_KEY_MASK_EN
    run_search("s_mask", 6'd8, 4'd4, 1'b0, 6'b111000, 1'b0);
    chk("mask_count_const", match_count, 8);
    rd_chk("rd_mask_17", 1, 7);
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buscar_asignar_seq.md
Name: buscar_asignar_seq

Overview:
- Parametrised, sequential successor to the combinational search/assign matrix.
- Holds a ROWS x COLS matrix of DATA_W-bit cells; each cell is {tag field (TAG_W = DATA_W-KEY_W), value field (KEY_W)}.
- On a start request it scans the cells one per clock in row-major order, finds unassigned cells whose value equals a key, and writes the supplied tag into them.
- Reports the match count and the first match position; sits between the board-load logic and the game/display controller.

Parameters:
- ROWS, 8, matrix rows
- COLS, 8, matrix columns
- DATA_W, 10, cell width
- KEY_W, 6, value field width; TAG_W = DATA_W-KEY_W must be >= 1
- Derived: RW = $clog2(ROWS), CW = $clog2(COLS), NW = $clog2(ROWS*COLS+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  load-port write strobe
- wr_row  in  RW  write row
- wr_col  in  CW  write column
- wr_data  in  DATA_W  write data
- rd_row  in  RW  read row
- rd_col  in  CW  read column
- rd_data  out  DATA_W  registered read data
- start  in  1  start request; sampled only in IDLE
- key  in  KEY_W  value to search
- tag  in  TAG_W  tag to assign
- first_only  in  1  1 = stop at first match, 0 = assign all matches
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle completion pulse
- found  out  1  at least one match in last search
- match_count  out  NW  matches in last search
- first_row  out  RW  row of first match
- first_col  out  CW  column of first match

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all memory cells, rd_data, busy, done, found, match_count, first_row and first_col go to 0. Reset mid-scan aborts the search: no done pulse, partial assignments discarded.
- FSM states:
  - IDLE -> SCAN on start=1. Latch key, tag and first_only; index = 0; clear count, found and first_row/first_col.
  - SCAN: examine cell[index] each cycle. Match = (value field == key) && (tag field == 0). On a match, same edge: write the tag field (value field unchanged), increment count, and record the position if it is the first match.
  - SCAN -> DONE on the last index (ROWS*COLS-1), or on the first match when first_only=1; otherwise index increments.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency, start accepted at edge 0:
  - first_only=0: done high in the cycle after edge ROWS*COLS (65 cycles for 8x8).
  - first_only=1 with first match at linear index k: done high after edge k+1.
  - No match: same timing as first_only=0.
- Result outputs hold their values until the next accepted start. match_count saturates naturally, since its maximum is ROWS*COLS.
- tag==0 gives a search-only pass: matches are counted but cells stay unassigned.
- Load-port writes are honoured only in IDLE and ignored while busy. start while busy is ignored.
- Read port: rd_data is cell[rd_row][rd_col] one cycle later. It is valid in every state and reflects writes committed by the previous edge.
- Row/column indices outside ROWS/COLS (non-power-of-2 sizes): writes ignored, reads return 0.

Optional Feature:
- Macro BUSCAR_KEY_MASK_EN.
- When defined: adds input key_mask [KEY_W], latched at start. The value comparison becomes (value & mask) == (key & mask); mask all-ones equals the base behaviour.
- When undefined: the port is absent and the comparison is full-width equality.

Decomposition:
- Package buscar_pkg: state enum (IDLE, SCAN, DONE) and default parameter constants.
- Helper function pulled from the package: index -> {row, col} conversion.
- Sub-module buscar_cell_cmp: combinational match decision (masked or unmasked) and next-cell data; everything else lives in the top.

Test Plan:
- Reset, then load cell i = i % 64 for 8x8; start key=5, tag=3, first_only=0 -> done at 65 cycles after start, match_count=1, first=(0,5), rd_data at (0,5) = {3,5}.
- Load all cells with 7; start key=7, tag=1, first_only=1 -> done after 2 cycles, count=1, first=(0,0); only (0,0) is tagged.
- Repeat the search with key=7, tag=2, first_only=0 -> count=63, first=(0,1); (0,0) keeps tag 1.
- Search key=63 on a board without 63 -> found=0, count=0, done at 65 cycles; start pulses and writes issued mid-scan have no effect.
- Drop rst mid-scan at index 30 -> outputs and memory cleared immediately, no done; a fresh search afterwards behaves normally.
- BUSCAR_KEY_MASK_EN defined: mask=6'b111000, key=8, cells 8..15 -> count=8.
